// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped, read-only instruction cache refilled by one RAM read burst per line
module instruction_cache #(
   parameter int unsigned LINE_IX_BITWIDTH         = 1,
   parameter int unsigned ADDRESS_BITWIDTH         = 32,
   parameter int unsigned DATA_BITWIDTH            = 32,
   parameter int unsigned DATA_IX_IN_LINE_BITWIDTH = 3,
   parameter int unsigned RAM_DEPTH_BITWIDTH       = 4,
   parameter int unsigned RAM_BURST_DATA_BITWIDTH  = 64,
   parameter int unsigned RAM_BURST_DATA_COUNT     = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable,
   input  logic [ADDRESS_BITWIDTH-1:0]        address,
   output logic [DATA_BITWIDTH-1:0]           data,
   output logic                               data_ready,
   output logic                               busy,
   output logic                               br_cmd,
   output logic                               br_cmd_en,
   output logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr,
   input  logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data,
   input  logic                               br_rd_data_valid,
   input  logic                               br_busy
);

   localparam int unsigned BYTE_OFS_W     = $clog2(DATA_BITWIDTH / 8);
   localparam int unsigned LINE_COUNT     = 1 << LINE_IX_BITWIDTH;
   localparam int unsigned WORDS_PER_LINE = 1 << DATA_IX_IN_LINE_BITWIDTH;
   localparam int unsigned WORDS_PER_BEAT = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
   localparam int unsigned BEAT_W         = $clog2(RAM_BURST_DATA_COUNT);
   localparam int unsigned WSEL_W         = DATA_IX_IN_LINE_BITWIDTH - BEAT_W;
   localparam int unsigned RAM_OFS_W      = $clog2(RAM_BURST_DATA_BITWIDTH / 8);
   localparam int unsigned LINE_LSB       = BYTE_OFS_W + DATA_IX_IN_LINE_BITWIDTH;
   localparam int unsigned TAG_LSB        = LINE_LSB + LINE_IX_BITWIDTH;
   localparam int unsigned TAG_W          = ADDRESS_BITWIDTH - TAG_LSB;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_FILL} state_t;

   state_t                             r_state;
   state_t                             w_state_next;
   logic [ADDRESS_BITWIDTH-1:0]        r_addr;
   logic [BEAT_W-1:0]                  r_beat;
   logic [LINE_COUNT-1:0]              r_valid;
   logic [TAG_W-1:0]                   r_tag [LINE_COUNT];
   logic [DATA_BITWIDTH-1:0]           r_mem [LINE_COUNT][WORDS_PER_LINE];
   logic [31:0]                        stat_cache_hits;
   logic [31:0]                        stat_cache_misses;

   logic [DATA_IX_IN_LINE_BITWIDTH-1:0] w_instr_ix;
   logic [LINE_IX_BITWIDTH-1:0]         w_line_ix;
   logic [TAG_W-1:0]                    w_tag;
   logic                                w_hit;
   logic [BEAT_W-1:0]                   w_req_beat;
   logic [WSEL_W-1:0]                   w_req_wsel;
   logic                                w_last_beat;
   logic [RAM_DEPTH_BITWIDTH-1:0]       w_ram_word;
   logic [RAM_DEPTH_BITWIDTH-1:0]       w_br_addr;
   logic                                w_accept;
   logic                                w_issue;
   logic                                w_beat_wr;

   // Split the latched request address into tag / line / instruction fields
   assign w_instr_ix  = r_addr[BYTE_OFS_W +: DATA_IX_IN_LINE_BITWIDTH];
   assign w_line_ix   = r_addr[LINE_LSB +: LINE_IX_BITWIDTH];
   assign w_tag       = r_addr[ADDRESS_BITWIDTH-1:TAG_LSB];
   assign w_hit       = r_valid[w_line_ix] && (r_tag[w_line_ix] == w_tag);
   assign w_req_beat  = w_instr_ix[DATA_IX_IN_LINE_BITWIDTH-1 -: BEAT_W];
   assign w_req_wsel  = w_instr_ix[WSEL_W-1:0];
   assign w_last_beat = (r_beat == BEAT_W'(RAM_BURST_DATA_COUNT - 1));
   assign w_ram_word  = RAM_DEPTH_BITWIDTH'(r_addr >> RAM_OFS_W);
   assign w_br_addr   = w_ram_word & ~RAM_DEPTH_BITWIDTH'(RAM_BURST_DATA_COUNT - 1);

   // The cache only ever reads from RAM
   assign br_cmd = 1'b0;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
   end

   // Next-state logic and per-cycle control strobes
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_issue      = 1'b0;
      w_beat_wr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_accept     = 1'b1;
               w_state_next = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            w_state_next = w_hit ? S_IDLE : S_MISS_REQ;
         end
         S_MISS_REQ: begin
            if (!br_busy) begin
               w_issue      = 1'b1;
               w_state_next = S_MISS_FILL;
            end
         end
         S_MISS_FILL: begin
            if (br_rd_data_valid) begin
               w_beat_wr = 1'b1;
               if (w_last_beat) w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Registered outputs, valid bits, beat counter and statistics
   always_ff @(posedge clk) begin
      if (!rst) begin
         data              <= '0;
         data_ready        <= 1'b0;
         busy              <= 1'b0;
         br_cmd_en         <= 1'b0;
         br_addr           <= '0;
         r_addr            <= '0;
         r_beat            <= '0;
         r_valid           <= '0;
         stat_cache_hits   <= '0;
         stat_cache_misses <= '0;
      end else begin
         br_cmd_en <= w_issue;
         if (w_accept) begin
            r_addr     <= address;
            data_ready <= 1'b0;
            busy       <= 1'b1;
         end
         if (r_state == S_LOOKUP) begin
            if (w_hit) begin
               stat_cache_hits <= stat_cache_hits + 32'd1;
               data            <= r_mem[w_line_ix][w_instr_ix];
               data_ready      <= 1'b1;
               busy            <= 1'b0;
            end else begin
               stat_cache_misses <= stat_cache_misses + 32'd1;
            end
         end
         if (w_issue) begin
            br_addr            <= w_br_addr;
            r_beat             <= '0;
            r_valid[w_line_ix] <= 1'b0;
         end
         if (w_beat_wr) begin
            r_beat <= r_beat + BEAT_W'(1);
            // Forward the requested word as soon as its beat arrives
            if (r_beat == w_req_beat) begin
               data       <= br_rd_data[32'(w_req_wsel) * DATA_BITWIDTH +: DATA_BITWIDTH];
               data_ready <= 1'b1;
            end
            if (w_last_beat) begin
               r_valid[w_line_ix] <= 1'b1;
               busy               <= 1'b0;
            end
         end
      end
   end

   // Line storage and tags; beat k fills words k*WORDS_PER_BEAT upward, low word first
   always_ff @(posedge clk) begin
      if (rst && w_beat_wr) begin
         for (int w = 0; w < WORDS_PER_BEAT; w++) begin
            r_mem[w_line_ix][{r_beat, WSEL_W'(w)}] <= br_rd_data[w * DATA_BITWIDTH +: DATA_BITWIDTH];
         end
         if (w_last_beat) r_tag[w_line_ix] <= w_tag;
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: directed vectors plus hand-written corner sequences for instruction_cache
module tb_instruction_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [31:0] address;
   logic [31:0] data;
   logic        data_ready;
   logic        busy;
   logic        br_cmd;
   logic        br_cmd_en;
   logic [3:0]  br_addr;
   logic [63:0] br_rd_data;
   logic        br_rd_data_valid;
   logic        br_busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] exp_data;
      bit          exp_miss;
      logic [3:0]  exp_br_addr;
      bit          exp_early;
      int          exp_hits;
      int          exp_misses;
   } vec_t;

   vec_t vecs  [10];
   vec_t vecs2 [3];

   instruction_cache dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (enable),
      .address          (address),
      .data             (data),
      .data_ready       (data_ready),
      .busy             (busy),
      .br_cmd           (br_cmd),
      .br_cmd_en        (br_cmd_en),
      .br_addr          (br_addr),
      .br_rd_data       (br_rd_data),
      .br_rd_data_valid (br_rd_data_valid),
      .br_busy          (br_busy)
   );

   always #5 clk = ~clk;

   // RAM model: 4 beats, first one 3 cycles after the command is seen
   logic [63:0] ram [16];
   int          ram_cnt = -1;
   logic [3:0]  ram_base = '0;
   always @(negedge clk) begin
      br_rd_data_valid = 1'b0;
      if (!rst) begin
         ram_cnt = -1;
      end else if (br_cmd_en && br_cmd == 1'b0) begin
         ram_base = br_addr;
         ram_cnt  = 0;
      end else if (ram_cnt >= 0) begin
         ram_cnt++;
         if (ram_cnt >= 3) begin
            br_rd_data_valid = 1'b1;
            br_rd_data       = ram[ram_base + 4'(ram_cnt - 3)];
            if (ram_cnt == 6) ram_cnt = -1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_vec(input vec_t v, input string nm);
      int         cmd_cnt;
      int         cyc;
      logic [3:0] cmd_addr;
      bit         early;
      bit         done;
      cmd_cnt  = 0;
      cyc      = 0;
      cmd_addr = '0;
      early    = 1'b0;
      done     = 1'b0;
      @(negedge clk);
      enable  = 1'b1;
      address = v.addr;
      @(negedge clk);
      enable  = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (br_cmd_en) begin
            cmd_cnt++;
            cmd_addr = br_addr;
         end
         if (!busy) begin
            done = 1'b1;
            cyc  = c;
            break;
         end
         if (data_ready) early = 1'b1;
         @(negedge clk);
      end
      check({nm, "_done"}, 64'(done), 64'd1);
      check({nm, "_data"}, 64'(data), 64'(v.exp_data));
      check({nm, "_ready"}, 64'(data_ready), 64'd1);
      check({nm, "_cmd_cnt"}, 64'(cmd_cnt), v.exp_miss ? 64'd1 : 64'd0);
      check({nm, "_br_cmd"}, 64'(br_cmd), 64'd0);
      if (v.exp_miss) check({nm, "_br_addr"}, 64'(cmd_addr), 64'(v.exp_br_addr));
      else            check({nm, "_hit_latency"}, 64'(cyc), 64'd1);
      check({nm, "_early"}, 64'(early), 64'(v.exp_early));
      check({nm, "_hits"}, 64'(dut.stat_cache_hits), 64'(v.exp_hits));
      check({nm, "_misses"}, 64'(dut.stat_cache_misses), 64'(v.exp_misses));
   endtask

   initial begin
      int  cmd_cnt;
      logic [3:0] cmd_addr;
      bit  done;
      bit  seen;

      for (int i = 0; i < 16; i++) ram[i] = 64'(i) * 64'h0101_0101_0101_0101;
      ram[0]        = 64'h3F5A2E14_B7C6A980;
      ram[1][31:0]  = 32'hAB4C3E6F;
      ram[2][31:0]  = 32'hD5B8A9C4;
      ram[4][31:0]  = 32'h2F5E3C7A;
      ram[8][63:32] = 32'h0A1B2C3D;

      //           addr    data          miss br  early hits miss
      vecs[0] = '{32'd0,  32'hB7C6A980, 1'b1, 4'd0, 1'b1, 0, 1};
      vecs[1] = '{32'd4,  32'h3F5A2E14, 1'b0, 4'd0, 1'b0, 1, 1};
      vecs[2] = '{32'd8,  32'hAB4C3E6F, 1'b0, 4'd0, 1'b0, 2, 1};
      vecs[3] = '{32'd16, 32'hD5B8A9C4, 1'b0, 4'd0, 1'b0, 3, 1};
      vecs[4] = '{32'd32, 32'h2F5E3C7A, 1'b1, 4'd4, 1'b1, 3, 2};
      vecs[5] = '{32'd68, 32'h0A1B2C3D, 1'b1, 4'd8, 1'b1, 3, 3};
      vecs[6] = '{32'd0,  32'hB7C6A980, 1'b1, 4'd0, 1'b1, 3, 4};
      vecs[7] = '{32'd36, 32'h04040404, 1'b0, 4'd0, 1'b0, 4, 4};
      vecs[8] = '{32'd60, 32'h07070707, 1'b0, 4'd0, 1'b0, 5, 4};
      vecs[9] = '{32'd92, 32'h0B0B0B0B, 1'b1, 4'd8, 1'b0, 5, 5};

      // after a mid-burst reset: nothing is valid any more
      vecs2[0] = '{32'd96, 32'h0C0C0C0C, 1'b1, 4'd12, 1'b1, 0, 1};
      vecs2[1] = '{32'd0,  32'hB7C6A980, 1'b1, 4'd0,  1'b1, 0, 2};
      vecs2[2] = '{32'd4,  32'h3F5A2E14, 1'b0, 4'd0,  1'b0, 1, 2};

      rst        = 1'b0;
      enable     = 1'b0;
      address    = '0;
      br_busy    = 1'b0;
      br_rd_data = '0;
      repeat (3) @(negedge clk);
      check("rst_data", 64'(data), 64'd0);
      check("rst_ready", 64'(data_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cmd", 64'(br_cmd), 64'd0);
      check("rst_cmd_en", 64'(br_cmd_en), 64'd0);
      check("rst_br_addr", 64'(br_addr), 64'd0);
      check("rst_hits", 64'(dut.stat_cache_hits), 64'd0);
      check("rst_misses", 64'(dut.stat_cache_misses), 64'd0);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) apply_vec(vecs[i], $sformatf("v%0d", i));

      // RAM busy delays the command; enables while busy are ignored
      br_busy = 1'b1;
      @(negedge clk);
      enable  = 1'b1;
      address = 32'd128;
      @(negedge clk);
      enable  = 1'b0;
      cmd_cnt = 0;
      repeat (6) begin
         if (br_cmd_en) cmd_cnt++;
         @(negedge clk);
      end
      check("hold_no_cmd", 64'(cmd_cnt), 64'd0);
      check("hold_busy", 64'(busy), 64'd1);
      enable  = 1'b1;
      address = 32'd4;
      br_busy = 1'b0;
      @(negedge clk);
      enable   = 1'b0;
      done     = 1'b0;
      cmd_addr = 4'hF;
      for (int c = 0; c < 40; c++) begin
         if (br_cmd_en) begin
            cmd_cnt++;
            cmd_addr = br_addr;
         end
         if (!busy) begin
            done = 1'b1;
            break;
         end
         enable = (c == 3);
         @(negedge clk);
      end
      enable = 1'b0;
      check("hold_done", 64'(done), 64'd1);
      check("hold_cmd_cnt", 64'(cmd_cnt), 64'd1);
      check("hold_br_addr", 64'(cmd_addr), 64'd0);
      check("hold_data", 64'(data), 64'hB7C6A980);
      repeat (3) @(negedge clk);
      check("ignore_busy", 64'(busy), 64'd0);
      check("ignore_data", 64'(data), 64'hB7C6A980);
      check("ignore_ready", 64'(data_ready), 64'd1);
      check("ignore_hits", 64'(dut.stat_cache_hits), 64'd5);
      check("ignore_misses", 64'(dut.stat_cache_misses), 64'd6);

      // Reset in the middle of a refill burst
      @(negedge clk);
      enable  = 1'b1;
      address = 32'd96;
      @(negedge clk);
      enable = 1'b0;
      seen   = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (br_cmd_en) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("mid_cmd_seen", 64'(seen), 64'd1);
      repeat (4) @(negedge clk);
      check("mid_early_ready", 64'(data_ready), 64'd1);
      check("mid_early_busy", 64'(busy), 64'd1);
      check("mid_early_data", 64'(data), 64'h0C0C0C0C);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_data", 64'(data), 64'd0);
      check("mid_rst_ready", 64'(data_ready), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_cmd_en", 64'(br_cmd_en), 64'd0);
      check("mid_rst_br_addr", 64'(br_addr), 64'd0);
      check("mid_rst_hits", 64'(dut.stat_cache_hits), 64'd0);
      check("mid_rst_misses", 64'(dut.stat_cache_misses), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_idle", 64'(busy), 64'd0);

      for (int i = 0; i < 3; i++) apply_vec(vecs2[i], $sformatf("r%0d", i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between a CPU fetch port and a burst-mode RAM controller.
- On a hit it returns the 32-bit instruction from line storage.
- On a miss it fetches the whole line in one RAM read burst, refills the line and returns the requested instruction.
- It keeps hit and miss statistics counters.

Parameters:
- LINE_IX_BITWIDTH, 1: log2 of the number of cache lines.
- ADDRESS_BITWIDTH, 32: width of the byte address.
- DATA_BITWIDTH, 32: instruction width (4 bytes).
- DATA_IX_IN_LINE_BITWIDTH, 3: log2 of instructions per line (8, i.e. 32 B).
- RAM_DEPTH_BITWIDTH, 4: width of the RAM word address.
- RAM_BURST_DATA_BITWIDTH, 64: RAM beat width.
- RAM_BURST_DATA_COUNT, 4: beats per burst. Beats times beat width must equal line size.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- enable  in  1  fetch request strobe.
- address  in  ADDRESS_BITWIDTH  byte address of the instruction.
- data  out  DATA_BITWIDTH  fetched instruction.
- data_ready  out  1  data is valid.
- busy  out  1  cache is processing a request.
- br_cmd  out  1  RAM command: 0 = read, 1 = write. Always driven 0.
- br_cmd_en  out  1  RAM command strobe.
- br_addr  out  RAM_DEPTH_BITWIDTH  RAM word address (RAM_BURST_DATA_BITWIDTH-wide words).
- br_rd_data  in  RAM_BURST_DATA_BITWIDTH  burst read beat.
- br_rd_data_valid  in  1  beat valid.
- br_busy  in  1  RAM cannot accept a command.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low.
- Reset (rst low at a clock edge):
  - clears all line valid bits;
  - zeroes stat_cache_hits and stat_cache_misses;
  - drives data=0, data_ready=0, busy=0, br_cmd=0, br_cmd_en=0, br_addr=0;
  - state becomes IDLE.
  - Reset in the middle of a burst aborts the burst. The partially filled line stays invalid.
- Address split:
  - bits [1:0] are ignored;
  - next DATA_IX_IN_LINE_BITWIDTH bits = instruction index (bits [4:2] by default);
  - next LINE_IX_BITWIDTH bits = line index (bit [5]);
  - remaining upper bits = tag.
- Storage per line: valid bit, tag, 2^DATA_IX_IN_LINE_BITWIDTH instructions.
- Counters: stat_cache_hits and stat_cache_misses are internal 32-bit registers, readable hierarchically under exactly these names.
- IDLE:
  - enable=1 latches address; data_ready drops to 0 and busy rises to 1 on the next edge.
  - enable while busy=1 is ignored.
- Hit (line valid and tag equal):
  - stat_cache_hits increments;
  - the cycle after acceptance: data = line word, data_ready=1, busy=0;
  - returns to IDLE.
- Miss:
  - stat_cache_misses increments once.
  - State MISS_REQ: wait for br_busy=0, then pulse br_cmd_en=1 for exactly one cycle with br_cmd=0 and br_addr = address[ADDRESS_BITWIDTH-1:3] truncated to RAM_DEPTH_BITWIDTH, low log2(RAM_BURST_DATA_COUNT) bits forced to 0 (line aligned).
  - State MISS_FILL: each cycle with br_rd_data_valid=1 writes the next beat into the line, beat k at line bytes [8k, 8k+7].
  - Within a beat, bits [31:0] hold the lower-addressed instruction and bits [63:32] the higher (little-endian).
  - When the beat containing the requested instruction arrives, data and data_ready=1 are set on that edge, possibly before the burst ends.
  - After the final beat: tag written, valid=1 (eviction of the previous occupant), busy=0, state IDLE.
- data_ready and data hold until the next accepted enable.
- Beats arriving outside MISS_FILL are ignored.
- Ordering: a new request is only accepted when busy=0, so a burst is never interrupted.

Test Plan:

RAM image for all scenarios: 16 words; word0 low 32 bits = B7C6A980, high = 3F5A2E14; word1 low = AB4C3E6F; word2 low = D5B8A9C4; word4 low = 2F5E3C7A; word8 high = 0A1B2C3D. The RAM model delivers 4 beats starting 3 cycles after the command.

1. Release reset, enable at address 0 → br_cmd_en pulse with br_addr=0, br_cmd=0; stat_cache_misses=1; data=B7C6A980 with data_ready=1; busy drops after the 4th beat.
2. Then address 4 → hit, no RAM command; stat_cache_hits=1; data=3F5A2E14 one cycle after enable.
3. Address 8 then 16 → hits; stat_cache_hits=2 and 3; data=AB4C3E6F then D5B8A9C4.
4. Address 32 → miss on line 1; br_addr=4; stat_cache_misses=2; data=2F5E3C7A.
5. Address 68 → miss evicting line 0; br_addr=8; stat_cache_misses=3; data=0A1B2C3D. A following fetch of address 0 misses again (misses=4).
6. Edge cases:
   - Hold br_busy=1 during a miss → br_cmd_en is delayed until br_busy=0.
   - Assert rst low mid-burst → counters=0, data_ready=0, busy=0; a re-fetch of the same address misses.
   - Enable pulses while busy=1 are ignored.
